load_store_unit: RTL

Memory-access stage directly downstream of the ALU. Takes the ALU result as the effective address, together with store data and a funct3 width code. Runs one RV32I load or store at a time against a single-port data memory using a request/grant/response handshake. Returns aligned, sign- or zero-extended load data, plus a misaligned-access flag, to the write-back stage.

---
 rtl/lsu_definitions.sv | 25 ++
 rtl/lsu_align.sv | 73 +++++++
 rtl/load_store_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/lsu_definitions.sv
// Shared definitions for the load/store unit: funct3 width codes, FSM states and
// the captured per-operation metadata.
package lsu_definitions;

  localparam int BE_WIDTH = 4;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_t;

  typedef struct packed {
    logic       is_load;
    logic       is_store;
    logic [2:0] funct3;
    logic [4:0] rd;
  } op_meta_t;

endpackage

// File: rtl/lsu_align.sv
// Lane logic for the load/store unit: byte enables, store steering, fault decode, load extension.
// Purely combinational (zero latency); no flow control.
module lsu_align
  import lsu_definitions::*;
(
  input  logic [1:0]          off,
  input  logic [2:0]          funct3,
  input  logic [31:0]         wdata,
  input  logic [31:0]         rdata,
  output logic [BE_WIDTH-1:0] be,
  output logic [31:0]         wdata_lane,
  output logic                fault,
  output logic [31:0]         rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    fault = 1'b0;
    case (funct3)
      LB, LBU: fault = 1'b0;
      LH, LHU: fault = off[0];
      LW:      fault = |off;
      default: fault = 1'b1;
    endcase
  end

  // Unsigned load codes share the size bits with their signed counterparts.
  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    case ({1'b0, funct3[1:0]})
      SB: begin
        be         = 4'b0001 << off;
        wdata_lane = {4{wdata[7:0]}};
      end
      SH: begin
        be         = off[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        wdata_lane = wdata;
      end
    endcase
  end

  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    rdata_ext = '0;
    case (funct3)
      LB:      rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      LH:      rdata_ext = {{16{half_sel[15]}}, half_sel};
      LW:      rdata_ext = rdata;
      LBU:     rdata_ext = {24'd0, byte_sel};
      LHU:     rdata_ext = {16'd0, half_sel};
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: one load/store at a time over req/gnt/rvalid; store wb at T+2, load at T+3, fault/no-op at T+1.
// in_ready only in IDLE; mem_req held until gnt; each missing gnt/rvalid adds a cycle; no write-back backpressure.
module load_store_unit
  import lsu_definitions::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_is_load,
  input  logic                  in_is_store,
  input  logic [2:0]            in_funct3,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  input  logic [4:0]            in_rd,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BE_WIDTH-1:0]   mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  misaligned
);

  lsu_state_t state, state_nxt;

  op_meta_t              meta_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  fault_q;

  logic                  idle, accept, in_ld, in_st, in_mem, accept_fault;
  logic [1:0]            al_off;
  logic [2:0]            al_funct3;
  logic [BE_WIDTH-1:0]   al_be;
  logic [DATA_WIDTH-1:0] al_wdata, al_rdata_ext;
  logic                  al_fault;
  logic                  in_resp, in_req, load_ok;

  assign idle   = (state == IDLE);
  assign accept = in_valid && idle;
  // A store wins when both kind bits are set.
  assign in_st  = in_is_store;
  assign in_ld  = in_is_load && !in_is_store;
  assign in_mem = in_ld || in_st;

  // The aligner looks at the incoming op while idle (fault decode at accept)
  // and at the captured op afterwards (lanes during REQ, extension during RESP).
  assign al_off    = idle ? in_addr[1:0] : addr_q[1:0];
  assign al_funct3 = idle ? in_funct3    : meta_q.funct3;

  lsu_align u_align (
    .off        (al_off),
    .funct3     (al_funct3),
    .wdata      (wdata_q),
    .rdata      (rdata_q),
    .be         (al_be),
    .wdata_lane (al_wdata),
    .fault      (al_fault),
    .rdata_ext  (al_rdata_ext)
  );

  assign accept_fault = in_mem && al_fault;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (!in_mem || accept_fault) state_nxt = RESP;
          else                         state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_gnt) state_nxt = meta_q.is_store ? RESP : WAIT;
      end
      WAIT: begin
        if (mem_rvalid) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      if (accept) begin
        meta_q  <= '{is_load: in_ld, is_store: in_st, funct3: in_funct3, rd: in_rd};
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
        fault_q <= accept_fault;
      end
      if (state == WAIT && mem_rvalid) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign in_req  = (state == REQ);
  assign in_resp = (state == RESP);
  assign load_ok = in_resp && meta_q.is_load && !fault_q;

  assign in_ready   = idle;
  assign mem_req    = in_req;
  assign mem_we     = in_req && meta_q.is_store;
  assign mem_addr   = in_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_be     = in_req ? al_be : '0;
  assign mem_wdata  = in_req ? al_wdata : '0;

  assign wb_valid   = in_resp;
  assign wb_we      = load_ok && (meta_q.rd != 5'd0);
  assign wb_rd      = in_resp ? meta_q.rd : 5'd0;
  assign wb_data    = load_ok ? al_rdata_ext : '0;
  assign misaligned = in_resp && fault_q;

endmodule
